// File: rtl/mul_div_unit.sv
// Iterative signed multiply / divide unit.
// Multiply: radix-2 Booth over a 65-bit accumulator, 32 iterations.
// Divide: non-restoring division on magnitudes with final sign correction,
// compiled in only when MUL_DIV_UNIT_DIVIDER_EN is defined; otherwise every
// start performs a multiply and div_by_zero is tied low.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] LastCnt = 6'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [5:0]       cnt_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, lo_q;

  // Booth working state: {A[WIDTH-1:0], Q[WIDTH-1:0], q_minus_1}
  logic [2*WIDTH:0] acc_q, mul_next;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mcand_q;

  logic             accept, last, dbz_start;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign accept = (state_q == StIdle) && start;
  assign last   = (state_q == StRun) && (cnt_q == LastCnt);

  // FSM state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = dbz_start ? StDone : StRun;
        end
      end
      StRun: begin
        if (last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, computed from the next state so busy/done can be registered
  always_comb begin
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  // One Booth step; the add is one bit wider than A so that subtracting
  // -2^(WIDTH-1) cannot overflow before the arithmetic shift.
  always_comb begin
    mul_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    case (acc_q[1:0])
      2'b01:   mul_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]} + {mcand_q[WIDTH-1], mcand_q};
      2'b10:   mul_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]} - {mcand_q[WIDTH-1], mcand_q};
      default: mul_sum = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
    endcase
    mul_next = {mul_sum, acc_q[WIDTH:1]};
  end

  // Iteration counter and multiplier working registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      acc_q   <= {{WIDTH{1'b0}}, b, 1'b0};
      mcand_q <= a;
    end else if (state_q == StRun) begin
      cnt_q   <= cnt_q + 6'd1;
      acc_q   <= mul_next;
    end
  end

`ifdef MUL_DIV_UNIT_DIVIDER_EN
  logic             op_q;
  logic             neg_quo_q, neg_rem_q;
  logic             dbz_q;
  logic [WIDTH+1:0] rem_q, rem_shift, rem_new, dvsr_ext;
  logic [WIDTH-1:0] quo_q, quo_new, dvsr_q;
  logic [WIDTH-1:0] abs_a, abs_b, rem_fix, div_hi, div_lo;

  assign dbz_start = accept && op && (b == '0);
  assign abs_a     = a[WIDTH-1] ? -a : a;
  assign abs_b     = b[WIDTH-1] ? -b : b;

  // One non-restoring step plus the final remainder fix-up and sign correction.
  // The remainder always ends below the divisor, so its low WIDTH bits suffice.
  always_comb begin
    dvsr_ext  = {2'b00, dvsr_q};
    rem_shift = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
    rem_new   = rem_q[WIDTH+1] ? (rem_shift + dvsr_ext) : (rem_shift - dvsr_ext);
    quo_new   = {quo_q[WIDTH-2:0], ~rem_new[WIDTH+1]};
    rem_fix   = rem_new[WIDTH-1:0] + (rem_new[WIDTH+1] ? dvsr_q : '0);
    div_lo    = neg_quo_q ? -quo_new : quo_new;
    div_hi    = neg_rem_q ? -rem_fix : rem_fix;
  end

  // Divider working registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q      <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      op_q      <= op;
      rem_q     <= '0;
      quo_q     <= abs_a;
      dvsr_q    <= abs_b;
      neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_rem_q <= a[WIDTH-1];
    end else if (state_q == StRun) begin
      rem_q     <= rem_new;
      quo_q     <= quo_new;
    end
  end

  // Divide-by-zero flag: set with the immediate result, cleared by the next accepted start
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dbz_q <= 1'b0;
    end else if (accept) begin
      dbz_q <= dbz_start;
    end
  end

  assign res_hi      = op_q ? div_hi : mul_next[2*WIDTH:WIDTH+1];
  assign res_lo      = op_q ? div_lo : mul_next[WIDTH:1];
  assign div_by_zero = dbz_q;
`else
  logic unused_op;

  assign unused_op   = op;
  assign dbz_start   = 1'b0;
  assign res_hi      = mul_next[2*WIDTH:WIDTH+1];
  assign res_lo      = mul_next[WIDTH:1];
  assign div_by_zero = 1'b0;
`endif

  // Registered outputs; hi/lo change only when a result is produced
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (dbz_start) begin
        hi_q <= a;
        lo_q <= '1;
      end else if (last) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
// Honours MUL_DIV_UNIT_DIVIDER_EN the same way as the design.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: {dbz, hi, lo}
  function automatic logic [64:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
`ifdef MUL_DIV_UNIT_DIVIDER_EN
    longint q, r;
`else
    logic unused_o;
    unused_o = o;
`endif
    sx = longint'($signed(x));
    sy = longint'($signed(y));
`ifdef MUL_DIV_UNIT_DIVIDER_EN
    if (o) begin
      if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
      q = sx / sy;
      r = sx % sy;
      return {1'b0, r[31:0], q[31:0]};
    end
`endif
    p = sx * sy;
    return {1'b0, p[63:0]};
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (clr === 1'b1) begin
      if (busy === 1'b1 && done === 1'b1) begin
        n_tests++;
        n_fail++;
        $display("FAIL busy_done_excl: got busy=1 done=1, want never both (cycle %0d)", cyc);
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pulse", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("hi", 64'(hi), 64'(mon_e.hi));
          check("lo", 64'(lo), 64'(mon_e.lo));
          check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
          check("done_cycle", 64'(cyc), 64'(mon_e.due));
        end
      end
    end
  end

  // Wait for idle, present one request for one edge, push its expectation.
  // lat = edges after the accepting edge until done is registered.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed,
                       input int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || done !== 1'b0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%b done=%b after 200 cycles, want idle", busy, done);
    end
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    exp_q.push_back('{eh, el, ed, cyc + 1 + lat});
    @(negedge clk);
    // Scramble operands after acceptance; the result must not depend on them.
    start = 1'b0;
    op    = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic issue_model(input logic o, input logic [31:0] x, input logic [31:0] y);
    logic [64:0] r;
    r = model(o, x, y);
    issue(o, x, y, r[63:32], r[31:0], r[64], r[64] ? 0 : 32);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic o;
    logic [31:0] x, y;
    clr   = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    clr = 1'b1;

    // 7 * -3 with busy/done profile; hi/lo stay at reset value during the run
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32);
    for (int k = 0; k < 32; k++) begin
      check("busy_run", 64'(busy), 64'd1);
      check("hi_hold_run", 64'(hi), 64'd0);
      @(negedge clk);
    end
    check("busy_end", 64'(busy), 64'd0);
    check("done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    wait_drain();

    // Most-negative squared, then confirm the result holds through the next run
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 32);
    wait_drain();
    issue(1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 32);
    repeat (5) @(negedge clk);
    check("hold_hi", 64'(hi), 64'h4000_0000);
    check("hold_lo", 64'(lo), 64'h0);
    wait_drain();

`ifdef MUL_DIV_UNIT_DIVIDER_EN
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 32);
    issue(1'b1, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0);
    wait_drain();
    repeat (3) @(negedge clk);
    check("dbz_hold", 64'(div_by_zero), 64'd1);
    issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
    check("dbz_clear", 64'(div_by_zero), 64'd0);
    wait_drain();
`else
    // op is ignored: these multiply
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, 32);
    issue(1'b1, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 1'b0, 32);
    wait_drain();
    check("dbz_tied", 64'(div_by_zero), 64'd0);
`endif

    // Start pulsed at E+10 with new operands must be ignored
    issue(1'b0, 32'd1000, 32'hFFFF_FC18, 32'hFFFF_FFFF, 32'hFFF0_BDC0, 1'b0, 32);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd3;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);

    // Reset mid-run
    issue(1'b0, 32'd12345, 32'd678, 32'd0, 32'd8369910, 1'b0, 32);
    repeat (14) @(negedge clk);
    clr = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (40) @(negedge clk);
    issue(1'b0, 32'hFFFF_FFFE, 32'd50000, 32'hFFFF_FFFF, 32'hFFFE_7960, 1'b0, 32);
    wait_drain();

    // Randomized back-to-back operations with corner-biased operands
    for (int i = 0; i < 60; i++) begin
      o = 1'($urandom_range(0, 1));
      x = pick();
      y = pick();
      issue_model(o, x, y);
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result half-width; only 32 is supported.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: clr  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: op  input  1  0 = signed multiply, 1 = signed divide; sampled with start.
REQ-006 Port: a  input  32  multiplicand / dividend (two's complement); sampled with start.
REQ-007 Port: b  input  32  multiplier / divisor (two's complement); sampled with start.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  one-cycle completion pulse; hi/lo valid from this cycle.
REQ-010 Port: div_by_zero  output  1  high with done when a divide had b = 0; held until next accepted start.
REQ-011 Port: hi  output  32  product[63:32] or remainder; feeds the HI register.
REQ-012 Port: lo  output  32  product[31:0] or quotient; feeds the LO register.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; the counter SHALL be 6-bit.
REQ-014 IDLE: start=1 at edge E SHALL latch a, b, op, clear the counter, and enter RUN.
REQ-014a The exception is divide with b=0, which SHALL enter DONE directly at E.
REQ-015 RUN SHALL perform one iteration per edge, for 32 iterations (edges E+1..E+32).
REQ-015a At edge E+32 the FSM SHALL register hi/lo and enter DONE.
REQ-016 DONE SHALL assert done for exactly one cycle and return to IDLE on the next edge.
REQ-016a Earliest next accepted start: edge E+34.
REQ-017 start SHALL be ignored in RUN and DONE; a, b, op changes after E SHALL not affect the result.
REQ-018 Multiply SHALL use radix-2 Booth recoding over a 65-bit accumulator.
REQ-018a Multiply result {hi,lo} SHALL equal the exact signed 64-bit product.
REQ-019 Divide SHALL use non-restoring division on magnitudes with sign correction.
REQ-019a Divide: lo = quotient truncated toward zero; hi = remainder, sign of dividend, |hi| < |b|.
REQ-020 Divide -2^31 / -1 SHALL give lo = 0x8000_0000 and hi = 0 (wrap, no flag).
REQ-021 Divide by zero SHALL give hi = a, lo = 0xFFFF_FFFF, div_by_zero = 1.
REQ-021a For divide by zero, done SHALL be asserted in the cycle after edge E (latency 1).
REQ-022 hi, lo, div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-022a hi and lo SHALL not change during RUN; results SHALL be held in separate working registers.
REQ-023 busy and done SHALL be registered outputs, never both high.

Reset
REQ-024 clr low SHALL asynchronously force: state IDLE, counter 0, busy 0, done 0, div_by_zero 0, hi 0, lo 0, working registers 0.
REQ-025 Reset during RUN or DONE SHALL discard the operation; no done pulse SHALL follow reset release.
REQ-026 After clr is released, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-027 Macro MUL_DIV_UNIT_DIVIDER_EN defined: divider logic SHALL be compiled in, and op=1 SHALL behave per REQ-019..REQ-021.
REQ-028 Macro absent: divider logic SHALL be omitted; every start SHALL perform multiply regardless of op; div_by_zero SHALL be tied 0.

Verification
REQ-029 Multiply: a=7, b=-3, start at E -> busy during E+1..E+32; done one cycle after E+32; hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
REQ-030 Multiply corner: a=b=0x8000_0000 -> hi=0x4000_0000, lo=0 at done.
REQ-031 Divide (DIVIDER_EN): a=-7, b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; a=0x8000_0000, b=-1 -> lo=0x8000_0000, hi=0.
REQ-032 Divide by zero: a=0x1234, b=0 -> done one cycle after E; hi=0x1234, lo=0xFFFF_FFFF, div_by_zero=1.
REQ-033 Start ignored while busy: start pulsed at E+10 with new operands -> original result unchanged, exactly one done pulse.
REQ-034 Reset mid-run: clr low at E+15 -> all outputs 0 immediately; no done pulse; new start after release completes correctly.
